// File: rtl/chip8_pkg.sv
// chip8_pkg: shared constants and the sprite engine state type.
package chip8_pkg;

  // Default geometry and bus widths for the sprite engine.
  localparam int DEF_SCR_W  = 128;
  localparam int DEF_SCR_H  = 64;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_PIX_W  = 2;

  // A lit pixel is stored as all-ones and an unlit pixel as zero.
  localparam logic [DEF_PIX_W-1:0] PIX_ON  = '1;
  localparam logic [DEF_PIX_W-1:0] PIX_OFF = '0;

  // Sprite engine sequencing states.
  typedef enum logic [2:0] {
    BLIT_IDLE,
    BLIT_FETCH,
    BLIT_LATCH,
    BLIT_PIXEL,
    BLIT_DONE
  } blit_state_e;

endpackage

// File: rtl/blit_coord.sv
// blit_coord: maps a sprite origin plus column/row offsets to a screen position
// and flags whether that position is visible. In wrap mode every position is
// visible and folded back onto the screen; in clip mode anything that runs past
// the right or bottom edge is reported as off-screen. Purely combinational so
// it can also serve address generation for a full-screen clear.
module blit_coord
  import chip8_pkg::*;
#(
  parameter int SCR_W = DEF_SCR_W,
  parameter int SCR_H = DEF_SCR_H
) (
  input  logic [$clog2(SCR_W)-1:0] x0_i,
  input  logic [$clog2(SCR_H)-1:0] y0_i,
  input  logic [3:0]               col_i,
  input  logic [3:0]               row_i,
  input  logic                     wrap_i,
  output logic [$clog2(SCR_W)-1:0] hpos_o,
  output logic [$clog2(SCR_H)-1:0] vpos_o,
  output logic                     on_screen_o
);
  localparam int HW = $clog2(SCR_W);
  localparam int VW = $clog2(SCR_H);

  logic [HW:0] hSum;
  logic [VW:0] vSum;

  // Sum with one carry bit; the carry marks a position past the screen edge,
  // and dropping it gives the wrapped position for free (power-of-2 screens).
  always_comb begin
    hSum        = {1'b0, x0_i} + (HW + 1)'(col_i);
    vSum        = {1'b0, y0_i} + (VW + 1)'(row_i);
    hpos_o      = hSum[HW-1:0];
    vpos_o      = vSum[VW-1:0];
    on_screen_o = wrap_i | ~(hSum[HW] | vSum[VW]);
  end

endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter: standalone DXYN sprite engine. Fetches sprite rows from RAM,
// XORs them into VRAM with a read-modify-write per pixel and reports whether
// any lit pixel was turned off (the VF collision flag).
// Build option: define SPRITE16_EN to make spr_n=0 draw a 16x16 sprite
// (two bytes per row, high byte first); without it spr_n=0 is a null draw.
module sprite_blitter
  import chip8_pkg::*;
#(
  parameter int SCR_W  = DEF_SCR_W,
  parameter int SCR_H  = DEF_SCR_H,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int PIX_W  = DEF_PIX_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     mode_wrap,
  input  logic [7:0]               spr_x,
  input  logic [7:0]               spr_y,
  input  logic [3:0]               spr_n,
  input  logic [ADDR_W-1:0]        spr_addr,
  output logic                     busy,
  output logic                     done,
  output logic                     collision,
  output logic [ADDR_W-1:0]        ram_addr,
  input  logic [7:0]               ram_dout,
  output logic [$clog2(SCR_W)-1:0] vram_hpos,
  output logic [$clog2(SCR_H)-1:0] vram_vpos,
  input  logic [PIX_W-1:0]         vram_pixelo,
  output logic [PIX_W-1:0]         vram_pixeli,
  output logic                     vram_we
);
  localparam int HW = $clog2(SCR_W);
  localparam int VW = $clog2(SCR_H);

  blit_state_e       state_q, state_d;
  logic [HW-1:0]     x0_q, x0_d;
  logic [VW-1:0]     y0_q, y0_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [4:0]        nRows_q, nRows_d;
  logic              wrap_q, wrap_d;
  logic              wide_q, wide_d;
  logic [3:0]        rowIdx_q, rowIdx_d;
  logic [3:0]        colIdx_q, colIdx_d;
  logic              byteIdx_q, byteIdx_d;
  logic [15:0]       shiftReg_q, shiftReg_d;
  logic              coll_q, coll_d;

  logic              wideReq;
  logic [HW-1:0]     coordH;
  logic [VW-1:0]     coordV;
  logic              onScreen;
  logic              spriteBit;
  logic              pixWe;
  logic              rowLast;
  logic [3:0]        colLast;
  logic [4:0]        rowOffset;
  logic [PIX_W-1:0]  pixOn;
  logic [PIX_W-1:0]  pixOff;

`ifdef SPRITE16_EN
  assign wideReq = (spr_n == 4'd0);
`else
  assign wideReq = 1'b0;
`endif

  assign pixOn  = {PIX_W{PIX_ON[0]}};
  assign pixOff = {PIX_W{PIX_OFF[0]}};

  blit_coord #(
    .SCR_W (SCR_W),
    .SCR_H (SCR_H)
  ) u_coord (
    .x0_i        (x0_q),
    .y0_i        (y0_q),
    .col_i       (colIdx_q),
    .row_i       (rowIdx_q),
    .wrap_i      (wrap_q),
    .hpos_o      (coordH),
    .vpos_o      (coordV),
    .on_screen_o (onScreen)
  );

  // Per-row bookkeeping: which sprite bit is current, where the row ends and
  // whether this is the final row of the sprite.
  always_comb begin
    spriteBit = wide_q ? shiftReg_q[15] : shiftReg_q[7];
    colLast   = wide_q ? 4'd15 : 4'd7;
    rowLast   = ({1'b0, rowIdx_q} == (nRows_q - 5'd1));
    rowOffset = wide_q ? {rowIdx_q, byteIdx_q} : {1'b0, rowIdx_q};
    pixWe     = (state_q == BLIT_PIXEL) && spriteBit && onScreen;
  end

  // Bus outputs: address/position buses idle at zero outside the states that use them.
  always_comb begin
    busy        = (state_q != BLIT_IDLE);
    done        = (state_q == BLIT_DONE);
    collision   = coll_q;
    ram_addr    = (state_q == BLIT_FETCH) ? (base_q + ADDR_W'(rowOffset)) : '0;
    vram_hpos   = (state_q == BLIT_PIXEL) ? coordH : '0;
    vram_vpos   = (state_q == BLIT_PIXEL) ? coordV : '0;
    vram_we     = pixWe;
    vram_pixeli = pixWe ? (vram_pixelo[0] ? pixOff : pixOn) : '0;
  end

  // Next-state logic: latch the request, fetch each row's bytes, then walk the
  // row one pixel per cycle, accumulating collision from the pixels we flip off.
  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    base_d     = base_q;
    nRows_d    = nRows_q;
    wrap_d     = wrap_q;
    wide_d     = wide_q;
    rowIdx_d   = rowIdx_q;
    colIdx_d   = colIdx_q;
    byteIdx_d  = byteIdx_q;
    shiftReg_d = shiftReg_q;
    coll_d     = coll_q;

    case (state_q)
      BLIT_IDLE: begin
        if (start) begin
          x0_d      = HW'(spr_x & 8'(SCR_W - 1));
          y0_d      = VW'(spr_y & 8'(SCR_H - 1));
          base_d    = spr_addr;
          wrap_d    = mode_wrap;
          wide_d    = wideReq;
          nRows_d   = wideReq ? 5'd16 : {1'b0, spr_n};
          rowIdx_d  = '0;
          colIdx_d  = '0;
          byteIdx_d = 1'b0;
          coll_d    = 1'b0;
          state_d   = ((spr_n != 4'd0) || wideReq) ? BLIT_FETCH : BLIT_DONE;
        end
      end

      BLIT_FETCH: begin
        state_d = BLIT_LATCH;
      end

      BLIT_LATCH: begin
        shiftReg_d = {shiftReg_q[7:0], ram_dout};
        if (wide_q && !byteIdx_q) begin
          byteIdx_d = 1'b1;
          state_d   = BLIT_FETCH;
        end else begin
          byteIdx_d = 1'b0;
          colIdx_d  = '0;
          state_d   = BLIT_PIXEL;
        end
      end

      BLIT_PIXEL: begin
        shiftReg_d = {shiftReg_q[14:0], 1'b0};
        if (pixWe && vram_pixelo[0]) begin
          coll_d = 1'b1;
        end
        if (colIdx_q == colLast) begin
          colIdx_d = '0;
          if (rowLast) begin
            state_d = BLIT_DONE;
          end else begin
            rowIdx_d = rowIdx_q + 4'd1;
            state_d  = BLIT_FETCH;
          end
        end else begin
          colIdx_d = colIdx_q + 4'd1;
        end
      end

      BLIT_DONE: begin
        state_d = BLIT_IDLE;
      end

      default: begin
        state_d = BLIT_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any draw in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= BLIT_IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      base_q     <= '0;
      nRows_q    <= '0;
      wrap_q     <= 1'b0;
      wide_q     <= 1'b0;
      rowIdx_q   <= '0;
      colIdx_q   <= '0;
      byteIdx_q  <= 1'b0;
      shiftReg_q <= '0;
      coll_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      base_q     <= base_d;
      nRows_q    <= nRows_d;
      wrap_q     <= wrap_d;
      wide_q     <= wide_d;
      rowIdx_q   <= rowIdx_d;
      colIdx_q   <= colIdx_d;
      byteIdx_q  <= byteIdx_d;
      shiftReg_q <= shiftReg_d;
      coll_q     <= coll_d;
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: drives sprite draws into the blitter with a bench-owned RAM
// and VRAM, predicting every cycle of each draw from the drawing rules.
module tb_sprite_blitter;
  localparam int SW = 128;
  localparam int SH = 64;
  localparam int AW = 12;
  localparam int PW = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          mode_wrap;
  logic [7:0]    spr_x;
  logic [7:0]    spr_y;
  logic [3:0]    spr_n;
  logic [AW-1:0] spr_addr;
  logic          busy;
  logic          done;
  logic          collision;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_dout;
  logic [6:0]    vram_hpos;
  logic [5:0]    vram_vpos;
  logic [PW-1:0] vram_pixelo;
  logic [PW-1:0] vram_pixeli;
  logic          vram_we;

  logic [7:0]    ram [4096];
  logic [1:0]    screen [SH][SW];
  logic [1:0]    modelImg [SH][SW];
  logic          clearScr;

  typedef struct {
    bit busy;
    bit done;
    bit we;
    int h;
    int v;
    int pix;
    bit chkAddr;
    int addr;
    bit coll;
  } expT;

  expT expQ[$];
  int  total = 0;
  int  bad = 0;
  int  drawCyc = 0;
  int  doneCycle = -1;
  int  weCount = 0;
  bit  lastColl = 1'b0;

  sprite_blitter #(
    .SCR_W (SW),
    .SCR_H (SH),
    .ADDR_W(AW),
    .PIX_W (PW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .mode_wrap  (mode_wrap),
    .spr_x      (spr_x),
    .spr_y      (spr_y),
    .spr_n      (spr_n),
    .spr_addr   (spr_addr),
    .busy       (busy),
    .done       (done),
    .collision  (collision),
    .ram_addr   (ram_addr),
    .ram_dout   (ram_dout),
    .vram_hpos  (vram_hpos),
    .vram_vpos  (vram_vpos),
    .vram_pixelo(vram_pixelo),
    .vram_pixeli(vram_pixeli),
    .vram_we    (vram_we)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Synchronous sprite RAM: data appears the cycle after the address.
  always @(posedge clk) ram_dout <= ram[ram_addr];

  // Bench VRAM: combinational read at the current position, clocked write.
  assign vram_pixelo = screen[vram_vpos][vram_hpos];
  always @(posedge clk) begin
    if (clearScr) begin
      for (int v = 0; v < SH; v++)
        for (int h = 0; h < SW; h++)
          screen[v][h] <= 2'd0;
    end else if (vram_we) begin
      screen[vram_vpos][vram_hpos] <= vram_pixeli;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, wanted %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic expT mkE(input bit b, input bit d);
    expT e;
    e.busy = b; e.done = d; e.we = 1'b0; e.h = 0; e.v = 0; e.pix = 0;
    e.chkAddr = 1'b0; e.addr = 0; e.coll = 1'b0;
    return e;
  endfunction

  function automatic int screenDiff();
    int n = 0;
    for (int v = 0; v < SH; v++)
      for (int h = 0; h < SW; h++)
        if (screen[v][h] !== modelImg[v][h]) n++;
    return n;
  endfunction

  // Compare process: every cycle, check the DUT against the next predicted cycle
  // (or against idle behaviour when nothing is in flight); accepted writes are
  // folded into the model image as they are checked.
  always @(negedge clk) begin
    expT e;
    if (!reset_n) begin
      if (clearScr) begin
        for (int v = 0; v < SH; v++)
          for (int h = 0; h < SW; h++)
            modelImg[v][h] = 2'd0;
      end
      chk("rstBusy", int'(busy), 0);
      chk("rstDone", int'(done), 0);
      chk("rstWe", int'(vram_we), 0);
      chk("rstColl", int'(collision), 0);
      chk("rstAddr", int'(ram_addr), 0);
      lastColl = 1'b0;
    end else begin
      if (done) doneCycle = drawCyc;
      if (vram_we) weCount++;
      drawCyc++;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        chk("busy", int'(busy), int'(e.busy));
        chk("done", int'(done), int'(e.done));
        chk("we", int'(vram_we), int'(e.we));
        if (e.we) begin
          chk("hpos", int'(vram_hpos), e.h);
          chk("vpos", int'(vram_vpos), e.v);
          chk("pixeli", int'(vram_pixeli), e.pix);
          modelImg[e.v][e.h] = 2'(e.pix);
        end
        if (e.chkAddr) chk("ramAddr", int'(ram_addr), e.addr);
        if (e.done) begin
          chk("collision", int'(collision), int'(e.coll));
          lastColl = e.coll;
        end
      end else begin
        chk("idleBusy", int'(busy), 0);
        chk("idleDone", int'(done), 0);
        chk("idleWe", int'(vram_we), 0);
        chk("heldColl", int'(collision), int'(lastColl));
      end
    end
  end

  // Launch one draw and predict it: one idle cycle, then per row B fetch/latch
  // pairs and W pixel cycles, then a single done cycle.
  task automatic applyStimulus(input int x, input int y, input int n, input int addr,
                               input bit wrap);
    expT e;
    logic [1:0] scratch [SH][SW];
    logic [7:0] b;
    int bpr, w, rows, x0, y0, hh, vv;
    bit wide, coll, on;
    scratch = modelImg;
    x0 = x % SW;
    y0 = y % SH;
    wide = 1'b0;
`ifdef SPRITE16_EN
    wide = (n == 0);
`endif
    bpr  = wide ? 2 : 1;
    w    = wide ? 16 : 8;
    rows = wide ? 16 : n;
    coll = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; spr_x = 8'(x); spr_y = 8'(y); spr_n = 4'(n);
    spr_addr = AW'(addr); mode_wrap = wrap;
    drawCyc = 0; doneCycle = -1; weCount = 0;
    expQ.push_back(mkE(1'b0, 1'b0));
    for (int r = 0; r < rows; r++) begin
      for (int k = 0; k < bpr; k++) begin
        e = mkE(1'b1, 1'b0);
        e.chkAddr = 1'b1;
        e.addr = (addr + r * bpr + k) % 4096;
        expQ.push_back(e);
        expQ.push_back(mkE(1'b1, 1'b0));
      end
      for (int c = 0; c < w; c++) begin
        e = mkE(1'b1, 1'b0);
        b = ram[(addr + r * bpr + c / 8) % 4096];
        hh = x0 + c;
        vv = y0 + r;
        on = wrap || (hh < SW && vv < SH);
        if (b[7 - (c % 8)] && on) begin
          e.we = 1'b1;
          e.h = hh % SW;
          e.v = vv % SH;
          e.pix = scratch[e.v][e.h][0] ? 0 : 3;
          if (scratch[e.v][e.h][0]) coll = 1'b1;
          scratch[e.v][e.h] = 2'(e.pix);
        end
        expQ.push_back(e);
      end
    end
    e = mkE(1'b1, 1'b1);
    e.coll = coll;
    expQ.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    spr_x = 8'($urandom); spr_y = 8'($urandom); spr_n = 4'($urandom);
    spr_addr = AW'($urandom); mode_wrap = 1'($urandom);
  endtask

  task automatic waitDrain();
    for (int t = 0; t < 1000 && expQ.size() != 0; t++) begin
      @(negedge clk); #1;
    end
    chk("drainTimeout", expQ.size(), 0);
    expQ.delete();
    @(negedge clk); #1;
  endtask

  task automatic checkOutput(input string name, input int expDone, input int expWe,
                             input int expColl);
    chk({name, ".doneCycle"}, doneCycle, expDone);
    chk({name, ".writes"}, weCount, expWe);
    if (expColl >= 0) chk({name, ".coll"}, int'(collision), expColl);
    chk({name, ".screen"}, screenDiff(), 0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0; clearScr = 1'b1; start = 1'b0; mode_wrap = 1'b0;
    spr_x = '0; spr_y = '0; spr_n = '0; spr_addr = '0;
    for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
    ram[12'h200] = 8'hF0;
    ram[12'h210] = 8'hFF;
    ram[12'h220] = 8'h81;
    ram[12'h221] = 8'h81;
    repeat (3) @(negedge clk);
    #1;
    clearScr = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    $display("[TB] basic draw at origin");
    applyStimulus(0, 0, 1, 12'h200, 1'b0);
    waitDrain();
    checkOutput("first", 11, 4, 0);
    chk("model00", int'(modelImg[0][0]), 3);
    chk("model03", int'(modelImg[0][3]), 3);
    chk("model04", int'(modelImg[0][4]), 0);
    chk("scr03", int'(screen[0][3]), 3);

    $display("[TB] redraw erases and collides");
    applyStimulus(0, 0, 1, 12'h200, 1'b0);
    waitDrain();
    checkOutput("erase", 11, 4, 1);
    chk("scr00", int'(screen[0][0]), 0);

    $display("[TB] right edge clip then wrap");
    applyStimulus(126, 10, 1, 12'h210, 1'b0);
    waitDrain();
    checkOutput("clipX", 11, 2, 0);
    applyStimulus(126, 10, 1, 12'h210, 1'b1);
    waitDrain();
    checkOutput("wrapX", 11, 8, 1);
    chk("scr10_5", int'(screen[10][5]), 3);
    chk("scr10_126", int'(screen[10][126]), 0);

    $display("[TB] bottom edge wrap then clip");
    applyStimulus(0, 63, 2, 12'h220, 1'b1);
    waitDrain();
    checkOutput("wrapY", 21, 4, 0);
    chk("scr0_7", int'(screen[0][7]), 3);
    chk("scr63_0", int'(screen[63][0]), 3);
    applyStimulus(20, 63, 2, 12'h220, 1'b0);
    waitDrain();
    checkOutput("clipY", 21, 2, 0);

    $display("[TB] start while busy is ignored");
    applyStimulus(40, 20, 1, 12'h200, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; spr_x = 8'd0; spr_y = 8'd0; spr_n = 4'd3; spr_addr = 12'h210;
    @(posedge clk); #1;
    start = 1'b0;
    waitDrain();
    checkOutput("busyStart", 11, 4, 0);

    $display("[TB] reset in the middle of a row");
    applyStimulus(50, 30, 1, 12'h210, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    chk("preAbortWe", int'(vram_we), 1);
    chk("preAbortH", int'(vram_hpos), 54);
    reset_n = 1'b0;
    #1;
    chk("abortWe", int'(vram_we), 0);
    chk("abortBusy", int'(busy), 0);
    expQ.delete();
    @(negedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk); #1;
    chk("partialScr", screenDiff(), 0);
    applyStimulus(50, 30, 1, 12'h210, 1'b0);
    waitDrain();
    checkOutput("afterReset", 11, 8, 1);

    $display("[TB] zero-row request");
    applyStimulus(60, 40, 0, 12'h300, 1'b1);
    waitDrain();
`ifdef SPRITE16_EN
    checkOutput("wide", 321, weCount, -1);
`else
    checkOutput("null", 1, 0, 0);
`endif

    $display("[TB] randomized draws");
    for (int i = 0; i < 14; i++) begin
      applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 4095)),
                    1'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      waitDrain();
    end
    chk("finalScreen", screenDiff(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
